fetch_align: RTL

- Fetch-side parcel aligner that produces the instruction stream consumed by the compressed-instruction decoder and the full-width decoder.
- Accepts 32-bit aligned fetch words and buffers them as 16-bit parcels in a circular queue.
- Presents one instruction per handshake: 16-bit compressed, or 32-bit, including 32-bit instructions split across two fetch words.
- Tracks the PC of each emitted instruction and supports redirect (flush) to any halfword-aligned PC.

---
 rtl/fetch_align.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// fetch_align: fetch-side parcel aligner.
//
// Takes 32-bit aligned fetch words, keeps them as 16-bit parcels in a small
// circular queue, and hands out one instruction per handshake. The
// instruction is either a 16-bit compressed parcel or a 32-bit instruction
// built from two parcels. The two halves of a 32-bit instruction may come
// from different fetch words, and may sit on either side of the array wrap
// point. A redirect flushes the queue and restarts at any halfword-aligned PC.
//
// Parameters
//   DEPTH     parcel queue capacity (even, >= 4)
//   RESET_PC  PC of the first parcel after reset
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   fetch_valid/ready  fetch word handshake (ready = at least 2 free slots)
//   fetch_data         [15:0] lower-address parcel, [31:16] upper parcel
//   redirect           flush and restart at redirect_pc (bit 0 ignored)
//   instr_valid/ready  instruction handshake
//   instr              {16'b0,P0} when compressed, {P1,P0} otherwise
//   instr_pc           PC of the parcel at the head of the queue
//   instr_compressed   instr[1:0] != 2'b11
//
// Optional build macro FETCH_ALIGN_ERROR_EN adds fetch_error / instr_error.
// Each parcel then carries its word's error bit. An erroneous head parcel is
// emitted on its own, so a faulting fetch never waits for an upper half.

module fetch_align #(
  parameter int          DEPTH    = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
`ifdef FETCH_ALIGN_ERROR_EN
  input  logic        fetch_error,
  output logic        instr_error,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [IW:0] DEPTH_X    = (IW+1)'(DEPTH);
  localparam cnt_t        PUSH_LIMIT = cnt_t'(DEPTH - 2);

  // base + inc is always below 2*DEPTH, so one conditional subtract wraps it.
  function automatic idx_t wrap_add(input idx_t base, input logic [IW:0] inc);
    logic [IW:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[IW-1:0];
  endfunction

  logic [15:0] parcel_q [DEPTH];
  idx_t        head;
  cnt_t        count;
  logic [31:0] head_pc;
  logic        skip_low;

  idx_t        head_nx1;
  idx_t        head_nx2;
  idx_t        tail;
  idx_t        tail_nx1;
  logic [15:0] p0;
  logic [15:0] p1;
  logic        has_one;
  logic        has_two;
  logic        head_err;
  logic        dec_valid;
  logic        pop_two;
  logic        push;
  logic        pop;
  cnt_t        push_cnt;
  cnt_t        pop_cnt;

  logic        unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[0];

`ifdef FETCH_ALIGN_ERROR_EN
  logic [DEPTH-1:0] err_q;
  assign head_err = err_q[head];
`else
  assign head_err = 1'b0;
`endif

  assign head_nx1 = wrap_add(head, (IW+1)'(1));
  assign head_nx2 = wrap_add(head, (IW+1)'(2));
  assign tail     = wrap_add(head, (IW+1)'(count));
  assign tail_nx1 = wrap_add(tail, (IW+1)'(1));

  assign p0      = parcel_q[head];
  assign p1      = parcel_q[head_nx1];
  assign has_one = (count != '0);
  assign has_two = (count >= cnt_t'(2));

  // Decode looks only at registered queue state. Redirect just masks the
  // valid, so no pop can happen in the cycle that flushes the queue.
  always_comb begin
    dec_valid        = 1'b0;
    pop_two          = 1'b0;
    instr            = 32'h0;
    instr_compressed = 1'b0;
    if (has_one) begin
      if (head_err || p0[1:0] != 2'b11) begin
        dec_valid        = 1'b1;
        instr            = {16'h0, p0};
        instr_compressed = (p0[1:0] != 2'b11);
      end else if (has_two) begin
        dec_valid = 1'b1;
        pop_two   = 1'b1;
        instr     = {p1, p0};
      end
    end
  end

`ifdef FETCH_ALIGN_ERROR_EN
  always_comb begin
    instr_error = 1'b0;
    if (dec_valid) instr_error = head_err | (pop_two & err_q[head_nx1]);
  end
`endif

  assign instr_valid = dec_valid & ~redirect;
  assign instr_pc    = head_pc;

  // Registered count only; the redirect mask is the sole combinational term.
  assign fetch_ready = ~redirect & (count <= PUSH_LIMIT);

  assign push = fetch_valid & fetch_ready;
  assign pop  = instr_valid & instr_ready;

  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (push) push_cnt = skip_low ? cnt_t'(1) : cnt_t'(2);
    if (pop)  pop_cnt  = pop_two  ? cnt_t'(2) : cnt_t'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      count    <= '0;
      head_pc  <= RESET_PC;
      skip_low <= 1'b0;
      for (int i = 0; i < DEPTH; i++) parcel_q[i] <= 16'h0;
`ifdef FETCH_ALIGN_ERROR_EN
      err_q    <= '0;
`endif
    end else if (redirect) begin
      count    <= '0;
      head_pc  <= {redirect_pc[31:1], 1'b0};
      skip_low <= redirect_pc[1];
    end else begin
      // Push writes only slots beyond the current count, so it never
      // collides with the parcels a same-cycle pop consumes.
      if (push) begin
        if (skip_low) begin
          parcel_q[tail] <= fetch_data[31:16];
          skip_low       <= 1'b0;
`ifdef FETCH_ALIGN_ERROR_EN
          err_q[tail]    <= fetch_error;
`endif
        end else begin
          parcel_q[tail]     <= fetch_data[15:0];
          parcel_q[tail_nx1] <= fetch_data[31:16];
`ifdef FETCH_ALIGN_ERROR_EN
          err_q[tail]        <= fetch_error;
          err_q[tail_nx1]    <= fetch_error;
`endif
        end
      end
      if (pop) begin
        head    <= pop_two ? head_nx2 : head_nx1;
        head_pc <= head_pc + (pop_two ? 32'd4 : 32'd2);
      end
      count <= count + push_cnt - pop_cnt;
    end
  end

endmodule
